// File: rtl/apb_master.sv
// APB requester: turns single-beat valid/ready commands into APB setup/access
// transfers, with a wait-state watchdog that aborts stalled transfers.
//
// state  | meaning
// IDLE   | bus quiet, cmd_ready high, waiting for a command
// SETUP  | psel high, penable low, latched command on the bus
// ACCESS | psel and penable high, waiting for pready or watchdog expiry
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Last counter value of a stalled transfer; wraps harmlessly when disabled.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    localparam bit          WDOG_EN   = (TIMEOUT != 0);

    state_t             state, state_nxt;
    logic [15:0]        wait_cnt, wait_cnt_nxt;
    logic               psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_W-1:0]  paddr_nxt;
    logic [DATA_W-1:0]  pwdata_nxt;
    logic               rsp_valid_nxt, rsp_slverr_nxt, rsp_timeout_nxt;
    logic [DATA_W-1:0]  rsp_rdata_nxt;

    assign cmd_ready = (state == IDLE) && !prst;

    always_ff @(posedge pclk) begin
        if (prst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            psel        <= psel_nxt;
            penable     <= penable_nxt;
            pwrite      <= pwrite_nxt;
            paddr       <= paddr_nxt;
            pwdata      <= pwdata_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_slverr  <= rsp_slverr_nxt;
            rsp_timeout <= rsp_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        psel_nxt        = psel;
        penable_nxt     = penable;
        pwrite_nxt      = pwrite;
        paddr_nxt       = paddr;
        pwdata_nxt      = pwdata;
        rsp_valid_nxt   = 1'b0;
        rsp_rdata_nxt   = '0;
        rsp_slverr_nxt  = 1'b0;
        rsp_timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_nxt   = SETUP;
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                    pwrite_nxt  = cmd_write;
                    paddr_nxt   = cmd_addr;
                    pwdata_nxt  = cmd_write ? cmd_wdata : '0;
                end
            end
            SETUP: begin
                state_nxt    = ACCESS;
                penable_nxt  = 1'b1;
                wait_cnt_nxt = '0;
            end
            ACCESS: begin
                if (pready || (WDOG_EN && wait_cnt == WAIT_LAST)) begin
                    state_nxt     = IDLE;
                    wait_cnt_nxt  = '0;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    pwrite_nxt    = 1'b0;
                    paddr_nxt     = '0;
                    pwdata_nxt    = '0;
                    rsp_valid_nxt = 1'b1;
                    if (pready) begin
                        rsp_slverr_nxt = pslverr;
                        rsp_rdata_nxt  = (!pwrite && !pslverr) ? prdata : '0;
                    end else begin
                        rsp_slverr_nxt  = 1'b1;
                        rsp_timeout_nxt = 1'b1;
                    end
                end else if (wait_cnt != 16'hFFFF) begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
